// File: rtl/fetcher_if.sv
// Fetch-stage bundle: control from execute/decode, instruction-memory port and decoder-facing output.
// master = the fetcher itself, slave = everything around it.
interface fetcher_if #(
   parameter int IMEM_ADDR_W = 10
);
   logic                   FETCH_ENABLED;
   logic                   STALL;
   logic                   REDIRECT_VALID;
   logic [31:0]            REDIRECT_PC;
   logic                   IMEM_REQ;
   logic [IMEM_ADDR_W-1:0] IMEM_ADDR;
   logic [31:0]            IMEM_RDATA;
   logic                   INSTR_VALID;
   logic [31:0]            INSTR_OUT;
   logic [31:0]            PC_OUT;

   modport master (
      input  FETCH_ENABLED, STALL, REDIRECT_VALID, REDIRECT_PC, IMEM_RDATA,
      output IMEM_REQ, IMEM_ADDR, INSTR_VALID, INSTR_OUT, PC_OUT
   );

   modport slave (
      output FETCH_ENABLED, STALL, REDIRECT_VALID, REDIRECT_PC, IMEM_RDATA,
      input  IMEM_REQ, IMEM_ADDR, INSTR_VALID, INSTR_OUT, PC_OUT
   );
endinterface

// File: rtl/fetcher.sv
// Instruction fetch: word PC, one outstanding 1-cycle imem read, 2-entry {instr, pc} queue
// with valid/stall towards decode and a flushing redirect.
module fetcher #(
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          IMEM_ADDR_W = 10
) (
   input  logic      CLK,
   input  logic      RSTN,
   fetcher_if.master bus
);

   logic [31:0] pc_q;
   logic        inflight_q;
   logic [31:0] inflight_pc_q;
   logic [1:0]  count_q;
   logic [31:0] slot_instr_q [2];
   logic [31:0] slot_pc_q    [2];

   logic       head_valid;
   logic       instr_valid;
   logic       pop;
   logic       push;
   logic       issue;
   logic       wr_slot1;
   logic [2:0] occupancy;

   always_comb begin
      head_valid  = (count_q != 2'd0);
      instr_valid = head_valid && !bus.REDIRECT_VALID;
      pop         = instr_valid && !bus.STALL;
      push        = inflight_q && !bus.REDIRECT_VALID;
      // Room check counts the word already in flight and credits a same-cycle pop.
      occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      // Gated by RSTN so no request escapes while reset is held.
      issue       = RSTN && bus.FETCH_ENABLED && !bus.REDIRECT_VALID && (occupancy < 3'd2);
      // A full queue never coexists with an in-flight word, so a push lands in slot 0 or 1.
      wr_slot1    = (count_q == 2'd1) && !pop;
   end

   assign bus.IMEM_REQ    = issue;
   assign bus.IMEM_ADDR   = pc_q[IMEM_ADDR_W-1:0];
   assign bus.INSTR_VALID = instr_valid;
   assign bus.INSTR_OUT   = head_valid ? slot_instr_q[0] : 32'h0;
   assign bus.PC_OUT      = head_valid ? slot_pc_q[0]    : 32'h0;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'h0;
         count_q       <= 2'd0;
      end else if (bus.REDIRECT_VALID) begin
         pc_q       <= bus.REDIRECT_PC;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         if (issue) begin
            pc_q          <= pc_q + 32'd1;
            inflight_pc_q <= pc_q;
         end
         inflight_q <= issue;
         count_q    <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Slot 0 is the head; a pop shifts slot 1 down unless the incoming word takes slot 0.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               slot_instr_q[gi] <= 32'h0;
               slot_pc_q[gi]    <= 32'h0;
            end else if (push && (wr_slot1 == 1'(gi))) begin
               slot_instr_q[gi] <= bus.IMEM_RDATA;
               slot_pc_q[gi]    <= inflight_pc_q;
            end else if (pop && gi == 0) begin
               slot_instr_q[gi] <= slot_instr_q[1];
               slot_pc_q[gi]    <= slot_pc_q[1];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: directed scenarios plus a random run against a
// queue-based model of the fetch stage.
module tb_fetcher;

   logic CLK;
   logic RSTN;

   fetcher_if #(.IMEM_ADDR_W(10)) bus ();

   fetcher #(.RESET_PC(32'h0), .IMEM_ADDR_W(10)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus.master)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Instruction memory: word at address a is A000_0000 + a; garbage when no request.
   always @(posedge CLK) begin
      if (bus.IMEM_REQ) bus.IMEM_RDATA <= 32'hA000_0000 + {22'h0, bus.IMEM_ADDR};
      else              bus.IMEM_RDATA <= $urandom;
   end

   int checks = 0;
   int fails  = 0;

   // Model: next PC, the word in flight, and the PCs sitting in the queue.
   logic [31:0] m_pc;
   bit          m_inf;
   logic [31:0] m_ipc;
   logic [31:0] mq[$];
   logic [31:0] dut_seen[$];

   logic        exp_valid;
   logic [31:0] exp_pc;
   logic [31:0] exp_instr;
   logic        exp_req;
   logic [9:0]  exp_addr;

   function automatic logic [31:0] mem_word(logic [31:0] pc);
      return 32'hA000_0000 + {22'h0, pc[9:0]};
   endfunction

   task automatic m_reset();
      m_pc  = 32'h0;
      m_inf = 1'b0;
      m_ipc = 32'h0;
      mq.delete();
   endtask

   task automatic model_outputs();
      int room;
      exp_valid = (mq.size() != 0) && !bus.REDIRECT_VALID;
      exp_pc    = (mq.size() != 0) ? mq[0] : 32'h0;
      exp_instr = (mq.size() != 0) ? mem_word(mq[0]) : 32'h0;
      room      = mq.size() + int'(m_inf) - int'(exp_valid && !bus.STALL);
      exp_req   = bus.FETCH_ENABLED && !bus.REDIRECT_VALID && (room < 2);
      exp_addr  = m_pc[9:0];
   endtask

   // One clock: advance the model across the edge and record what the DUT handed over.
   task automatic tick();
      bit          pop, iss, redir;
      logic [31:0] rpc;
      model_outputs();
      pop   = exp_valid && !bus.STALL;
      iss   = exp_req;
      redir = bus.REDIRECT_VALID;
      rpc   = bus.REDIRECT_PC;
      if (bus.INSTR_VALID && !bus.STALL) dut_seen.push_back(bus.PC_OUT);
      @(posedge CLK);
      if (redir) begin
         mq.delete();
         m_inf = 1'b0;
         m_pc  = rpc;
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_inf) mq.push_back(m_ipc);
         if (iss) begin
            m_ipc = m_pc;
            m_pc  = m_pc + 32'd1;
         end
         m_inf = iss;
      end
      checks++;
      if (mq.size() > 2) begin
         fails++;
         $display("FAIL queue_overflow: model occupancy %0d, limit 2", mq.size());
      end
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      bus.FETCH_ENABLED  = 1'b1;
      bus.STALL          = 1'b0;
      bus.REDIRECT_VALID = 1'b0;
      bus.REDIRECT_PC    = 32'h0;
      repeat (2) @(negedge CLK);
      #1;
      checks++;
      if (bus.IMEM_REQ !== 1'b0 || bus.INSTR_VALID !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: req=%b valid=%b, want 0/0", bus.IMEM_REQ, bus.INSTR_VALID);
      end
      checks++;
      if (bus.INSTR_OUT !== 32'h0 || bus.PC_OUT !== 32'h0) begin
         fails++;
         $display("FAIL reset_data: instr=%h pc=%h, want 0/0", bus.INSTR_OUT, bus.PC_OUT);
      end
      @(negedge CLK);
      RSTN = 1'b1;
      m_reset();
      dut_seen.delete();
      $display("reset: outputs idle while RSTN low");
   endtask

   task automatic test_sequential();
      for (int c = 0; c < 12; c++) begin
         #1;
         model_outputs();
         checks++;
         if (bus.INSTR_VALID !== exp_valid || bus.PC_OUT !== exp_pc || bus.INSTR_OUT !== exp_instr) begin
            fails++;
            $display("FAIL seq_head c%0d: got v=%b pc=%h ins=%h, want v=%b pc=%h ins=%h",
                     c, bus.INSTR_VALID, bus.PC_OUT, bus.INSTR_OUT, exp_valid, exp_pc, exp_instr);
         end
         checks++;
         if (bus.IMEM_REQ !== exp_req || bus.IMEM_ADDR !== exp_addr) begin
            fails++;
            $display("FAIL seq_req c%0d: got req=%b addr=%h, want req=%b addr=%h",
                     c, bus.IMEM_REQ, bus.IMEM_ADDR, exp_req, exp_addr);
         end
         if (c >= 2) begin
            checks++;
            if (bus.INSTR_VALID !== 1'b1 || bus.PC_OUT !== 32'(c - 2) ||
                bus.INSTR_OUT !== 32'hA000_0000 + 32'(c - 2)) begin
               fails++;
               $display("FAIL seq_stream c%0d: got v=%b pc=%h ins=%h, want v=1 pc=%h",
                        c, bus.INSTR_VALID, bus.PC_OUT, bus.INSTR_OUT, 32'(c - 2));
            end
         end
         tick();
      end
      $display("sequential: 12 cycles streamed");
   endtask

   task automatic test_stall();
      logic [31:0] held;
      dut_seen.delete();
      for (int c = 0; c < 14; c++) begin
         bus.STALL = (c >= 2 && c < 7);
         #1;
         model_outputs();
         if (c == 2) held = exp_pc;
         checks++;
         if (bus.INSTR_VALID !== exp_valid || bus.PC_OUT !== exp_pc || bus.INSTR_OUT !== exp_instr) begin
            fails++;
            $display("FAIL stall_head c%0d: got v=%b pc=%h ins=%h, want v=%b pc=%h ins=%h",
                     c, bus.INSTR_VALID, bus.PC_OUT, bus.INSTR_OUT, exp_valid, exp_pc, exp_instr);
         end
         checks++;
         if (bus.IMEM_REQ !== exp_req || bus.IMEM_ADDR !== exp_addr) begin
            fails++;
            $display("FAIL stall_req c%0d: got req=%b addr=%h, want req=%b addr=%h",
                     c, bus.IMEM_REQ, bus.IMEM_ADDR, exp_req, exp_addr);
         end
         if (c >= 3 && c < 7) begin
            checks++;
            if (bus.PC_OUT !== held || bus.IMEM_REQ !== 1'b0) begin
               fails++;
               $display("FAIL stall_hold c%0d: got pc=%h req=%b, want pc=%h req=0",
                        c, bus.PC_OUT, bus.IMEM_REQ, held);
            end
         end
         tick();
      end
      checks++;
      begin
         bit ok;
         ok = (dut_seen.size() >= 6);
         for (int i = 1; i < dut_seen.size(); i++)
            if (dut_seen[i] !== dut_seen[i-1] + 32'd1) ok = 1'b0;
         if (!ok) begin
            fails++;
            $display("FAIL stall_order: %0d pcs delivered, sequence not contiguous", dut_seen.size());
         end
      end
      $display("stall: 5-cycle stall, %0d pcs delivered", dut_seen.size());
   endtask

   task automatic test_redirect();
      @(negedge CLK);
      RSTN = 1'b0;
      @(negedge CLK);
      RSTN = 1'b1;
      m_reset();
      for (int c = 0; c < 14; c++) begin
         bus.REDIRECT_VALID = (c == 7);
         bus.REDIRECT_PC    = 32'h40;
         if (c == 7) dut_seen.delete();
         #1;
         model_outputs();
         checks++;
         if (bus.INSTR_VALID !== exp_valid || bus.PC_OUT !== exp_pc || bus.INSTR_OUT !== exp_instr ||
             bus.IMEM_REQ !== exp_req || bus.IMEM_ADDR !== exp_addr) begin
            fails++;
            $display("FAIL redir_model c%0d: got v=%b pc=%h req=%b addr=%h, want v=%b pc=%h req=%b addr=%h",
                     c, bus.INSTR_VALID, bus.PC_OUT, bus.IMEM_REQ, bus.IMEM_ADDR,
                     exp_valid, exp_pc, exp_req, exp_addr);
         end
         if (c == 7) begin
            checks++;
            if (bus.INSTR_VALID !== 1'b0 || bus.IMEM_REQ !== 1'b0) begin
               fails++;
               $display("FAIL redir_cycle: got v=%b req=%b, want 0/0", bus.INSTR_VALID, bus.IMEM_REQ);
            end
         end
         if (c == 8) begin
            checks++;
            if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 10'h40) begin
               fails++;
               $display("FAIL redir_issue: got req=%b addr=%h, want 1/040", bus.IMEM_REQ, bus.IMEM_ADDR);
            end
         end
         if (c == 10) begin
            checks++;
            if (bus.INSTR_VALID !== 1'b1 || bus.PC_OUT !== 32'h40 || bus.INSTR_OUT !== 32'hA000_0040) begin
               fails++;
               $display("FAIL redir_target: got v=%b pc=%h ins=%h, want 1/40/a0000040",
                        bus.INSTR_VALID, bus.PC_OUT, bus.INSTR_OUT);
            end
         end
         tick();
      end
      bus.REDIRECT_VALID = 1'b0;
      checks++;
      begin
         bit bad;
         bad = (dut_seen.size() == 0);
         foreach (dut_seen[i])
            if (dut_seen[i] == 32'd5 || dut_seen[i] == 32'd6 || dut_seen[i] == 32'd7) bad = 1'b1;
         if (bad) begin
            fails++;
            $display("FAIL redir_flush: wrong-path pc delivered or nothing delivered (%0d pcs)", dut_seen.size());
         end
      end
      $display("redirect: to 0x40 mid-stream");
   endtask

   task automatic test_redirect_stall();
      bit got;
      bus.STALL = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         #1;
         model_outputs();
         checks++;
         if (bus.INSTR_VALID !== exp_valid || bus.PC_OUT !== exp_pc || bus.IMEM_REQ !== exp_req) begin
            fails++;
            $display("FAIL rstall_fill c%0d: got v=%b pc=%h req=%b, want v=%b pc=%h req=%b",
                     c, bus.INSTR_VALID, bus.PC_OUT, bus.IMEM_REQ, exp_valid, exp_pc, exp_req);
         end
         tick();
         got = (mq.size() == 2);
      end
      checks++;
      if (!got) begin
         fails++;
         $display("FAIL rstall_full: queue did not fill within 10 cycles");
      end
      for (int c = 0; c < 5; c++) begin
         bus.REDIRECT_VALID = (c == 0);
         bus.REDIRECT_PC    = 32'h10;
         #1;
         model_outputs();
         checks++;
         if (bus.INSTR_VALID !== exp_valid || bus.PC_OUT !== exp_pc || bus.INSTR_OUT !== exp_instr ||
             bus.IMEM_REQ !== exp_req || bus.IMEM_ADDR !== exp_addr) begin
            fails++;
            $display("FAIL rstall_model c%0d: got v=%b pc=%h req=%b addr=%h, want v=%b pc=%h req=%b addr=%h",
                     c, bus.INSTR_VALID, bus.PC_OUT, bus.IMEM_REQ, bus.IMEM_ADDR,
                     exp_valid, exp_pc, exp_req, exp_addr);
         end
         tick();
      end
      bus.STALL = 1'b0;
      #1;
      checks++;
      if (bus.INSTR_VALID !== 1'b1 || bus.PC_OUT !== 32'h10 || bus.INSTR_OUT !== 32'hA000_0010) begin
         fails++;
         $display("FAIL rstall_release: got v=%b pc=%h ins=%h, want 1/10/a0000010",
                  bus.INSTR_VALID, bus.PC_OUT, bus.INSTR_OUT);
      end
      tick();
      $display("redirect_stall: flushed full queue, resumed at 0x10");
   endtask

   task automatic test_enable_low();
      logic [31:0] last_pc;
      bit          found;
      repeat (3) tick();
      bus.FETCH_ENABLED = 1'b0;
      last_pc = m_ipc;
      dut_seen.delete();
      for (int c = 0; c < 6; c++) begin
         #1;
         model_outputs();
         checks++;
         if (bus.INSTR_VALID !== exp_valid || bus.PC_OUT !== exp_pc || bus.INSTR_OUT !== exp_instr ||
             bus.IMEM_REQ !== exp_req) begin
            fails++;
            $display("FAIL enlow_model c%0d: got v=%b pc=%h req=%b, want v=%b pc=%h req=%b",
                     c, bus.INSTR_VALID, bus.PC_OUT, bus.IMEM_REQ, exp_valid, exp_pc, exp_req);
         end
         tick();
      end
      #1;
      checks++;
      if (bus.IMEM_REQ !== 1'b0 || bus.INSTR_VALID !== 1'b0) begin
         fails++;
         $display("FAIL enlow_idle: got req=%b v=%b, want 0/0", bus.IMEM_REQ, bus.INSTR_VALID);
      end
      found = 1'b0;
      foreach (dut_seen[i]) if (dut_seen[i] == last_pc) found = 1'b1;
      checks++;
      if (!found) begin
         fails++;
         $display("FAIL enlow_inflight: in-flight pc %h never delivered", last_pc);
      end
      bus.FETCH_ENABLED = 1'b1;
      tick();
      $display("enable_low: in-flight pc %h drained", last_pc);
   endtask

   task automatic test_async_reset();
      repeat (5) tick();
      #3;
      RSTN = 1'b0;
      #1;
      checks++;
      if (bus.IMEM_REQ !== 1'b0 || bus.INSTR_VALID !== 1'b0 ||
          bus.INSTR_OUT !== 32'h0 || bus.PC_OUT !== 32'h0) begin
         fails++;
         $display("FAIL areset_outputs: got req=%b v=%b ins=%h pc=%h, want all 0",
                  bus.IMEM_REQ, bus.INSTR_VALID, bus.INSTR_OUT, bus.PC_OUT);
      end
      @(negedge CLK);
      RSTN = 1'b1;
      m_reset();
      for (int c = 0; c < 6; c++) begin
         #1;
         model_outputs();
         checks++;
         if (bus.INSTR_VALID !== exp_valid || bus.PC_OUT !== exp_pc || bus.IMEM_ADDR !== exp_addr) begin
            fails++;
            $display("FAIL areset_restart c%0d: got v=%b pc=%h addr=%h, want v=%b pc=%h addr=%h",
                     c, bus.INSTR_VALID, bus.PC_OUT, bus.IMEM_ADDR, exp_valid, exp_pc, exp_addr);
         end
         tick();
      end
      $display("async_reset: mid-stream reset, restarted at RESET_PC");
   endtask

   task automatic test_wrap();
      bus.REDIRECT_VALID = 1'b1;
      bus.REDIRECT_PC    = 32'hFFFF_FFFF;
      tick();
      bus.REDIRECT_VALID = 1'b0;
      dut_seen.delete();
      for (int c = 0; c < 6; c++) begin
         #1;
         model_outputs();
         checks++;
         if (bus.INSTR_VALID !== exp_valid || bus.PC_OUT !== exp_pc || bus.INSTR_OUT !== exp_instr ||
             bus.IMEM_ADDR !== exp_addr) begin
            fails++;
            $display("FAIL wrap_model c%0d: got v=%b pc=%h ins=%h addr=%h, want v=%b pc=%h ins=%h addr=%h",
                     c, bus.INSTR_VALID, bus.PC_OUT, bus.INSTR_OUT, bus.IMEM_ADDR,
                     exp_valid, exp_pc, exp_instr, exp_addr);
         end
         tick();
      end
      checks++;
      if (dut_seen.size() < 2 || dut_seen[0] !== 32'hFFFF_FFFF || dut_seen[1] !== 32'h0) begin
         fails++;
         $display("FAIL wrap_order: got %0d pcs, first %h second %h, want ffffffff then 0",
                  dut_seen.size(), (dut_seen.size() > 0) ? dut_seen[0] : 32'hx,
                  (dut_seen.size() > 1) ? dut_seen[1] : 32'hx);
      end
      $display("wrap: ffffffff -> 0");
   endtask

   task automatic test_random();
      int errs_before;
      errs_before = fails;
      for (int c = 0; c < 400; c++) begin
         bus.STALL          = ($urandom_range(0, 9) < 3);
         bus.FETCH_ENABLED  = ($urandom_range(0, 9) < 8);
         bus.REDIRECT_VALID = ($urandom_range(0, 19) == 0);
         bus.REDIRECT_PC    = $urandom;
         #1;
         model_outputs();
         checks++;
         if (bus.INSTR_VALID !== exp_valid || bus.PC_OUT !== exp_pc || bus.INSTR_OUT !== exp_instr ||
             bus.IMEM_REQ !== exp_req || bus.IMEM_ADDR !== exp_addr) begin
            fails++;
            $display("FAIL random c%0d: got v=%b pc=%h ins=%h req=%b addr=%h, want v=%b pc=%h ins=%h req=%b addr=%h",
                     c, bus.INSTR_VALID, bus.PC_OUT, bus.INSTR_OUT, bus.IMEM_REQ, bus.IMEM_ADDR,
                     exp_valid, exp_pc, exp_instr, exp_req, exp_addr);
         end
         tick();
      end
      bus.REDIRECT_VALID = 1'b0;
      bus.STALL          = 1'b0;
      bus.FETCH_ENABLED  = 1'b1;
      $display("random: 400 cycles, %0d new failures", fails - errs_before);
   endtask

   initial begin
      bus.IMEM_RDATA = 32'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_enable_low();
      test_async_reset();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
